multicycle_control_v2: RTL and testbench

MULTICYCLE_CONTROL_V2 -- requirements
Module: multicycle_control_v2

---
 rtl/multicycle_control_v2_pkg.sv | 57 +++++
 rtl/multicycle_control_v2_out_decode.sv | 106 ++++++++++
 rtl/multicycle_control_v2.sv | 110 +++++++++++
 tb/tb_multicycle_control_v2.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_v2_pkg.sv
// Shared definitions for the multicycle controller: state codes, opcodes,
// ALU operation codes and the opcode classifier.
package multicycle_control_v2_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BEQ     = 4'd8,
    S_IEXEC   = 4'd9,
    S_IWB     = 4'd10,
    S_JUMP    = 4'd11,
    S_BNE     = 4'd12,
    S_ILLEGAL = 4'd13
  } state_e;

  typedef enum logic [3:0] {
    C_LW, C_SW, C_R, C_BEQ, C_BNE, C_ADDI, C_ANDI, C_ORI, C_J, C_BAD
  } op_class_e;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_FUNCT = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;

  function automatic op_class_e classify(input logic [5:0] op);
    case (op)
      OP_LW:   return C_LW;
      OP_SW:   return C_SW;
      OP_R:    return C_R;
      OP_BEQ:  return C_BEQ;
      OP_BNE:  return C_BNE;
      OP_ADDI: return C_ADDI;
      OP_ANDI: return C_ANDI;
      OP_ORI:  return C_ORI;
      OP_J:    return C_J;
      default: return C_BAD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_v2_out_decode.sv
// Moore output decode for the multicycle controller; mem_ready only
// qualifies the FETCH write strobes.
module mcc_out_decode
  import multicycle_control_v2_pkg::*;
#(
  parameter int ALUOP_W = 3
) (
  input  state_e               state,
  input  logic                 mem_ready,
  input  op_class_e            op_class,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 branch_ne,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 mem_to_reg,
  output logic                 ir_write,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           pc_source,
  output logic [ALUOP_W-1:0]   alu_op,
  output logic                 illegal_op
);

  logic [2:0] alu_sel;

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_sel       = ALU_ADD;
    illegal_op    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_sel   = ALU_FUNCT;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BEQ, S_BNE: begin
        alu_src_a     = 1'b1;
        alu_sel       = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (state == S_BNE);
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (op_class)
          C_ANDI:  alu_sel = ALU_AND;
          C_ORI:   alu_sel = ALU_OR;
          default: alu_sel = ALU_ADD;
        endcase
      end
      S_IWB:     reg_write = 1'b1;
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_ILLEGAL: illegal_op = 1'b1;
      default: ;
    endcase
  end

  assign alu_op = ALUOP_W'(alu_sel);

endmodule

// File: rtl/multicycle_control_v2.sv
// Multicycle CPU controller: state register, opcode class capture and
// retired-instruction counter; output decode lives in mcc_out_decode.
module multicycle_control_v2
  import multicycle_control_v2_pkg::*;
#(
  parameter int OPW      = 6,
  parameter int ALUOP_W  = 3,
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OPW-1:0]     opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_ne,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal_op,
  output logic [3:0]         state_o,
  output logic [CNT_W-1:0]   retired
);

  state_e           state_q, state_d;
  op_class_e        class_q, class_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  op_class_e        dec_class;
  logic             mem_rdy;

  assign mem_rdy = (MEM_WAIT != 0) ? mem_ready : 1'b1;
  // Opcodes wider than 6 bits are only legal with zero upper bits.
  assign dec_class = ((opcode >> 6) == '0) ? classify(opcode[5:0]) : C_BAD;

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    case (state_q)
      S_FETCH: if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        class_d = dec_class;
        case (dec_class)
          C_LW, C_SW:             state_d = S_MEMADR;
          C_R:                    state_d = S_EXEC;
          C_BEQ:                  state_d = S_BEQ;
          C_BNE:                  state_d = S_BNE;
          C_ADDI, C_ANDI, C_ORI:  state_d = S_IEXEC;
          C_J:                    state_d = S_JUMP;
          default:                state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_d = (class_q == C_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase

    retired_d = retired_q;
    if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_ILLEGAL)
      retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      class_q   <= C_BAD;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      retired_q <= retired_d;
    end
  end

  assign state_o = state_q;
  assign retired = retired_q;

  mcc_out_decode #(.ALUOP_W(ALUOP_W)) u_out_decode (
    .state         (state_q),
    .mem_ready     (mem_rdy),
    .op_class      (class_q),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (branch_ne),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_to_reg    (mem_to_reg),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_source     (pc_source),
    .alu_op        (alu_op),
    .illegal_op    (illegal_op)
  );

endmodule

// File: tb/tb_multicycle_control_v2.sv
// Directed bench: instance a honours mem_ready (CNT_W=16), instance b has
// MEM_WAIT=0 and CNT_W=4 for single-cycle timing and counter wrap.
module tb_multicycle_control_v2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance a
  logic        rst_a, mr_a;
  logic [5:0]  op_a;
  logic        pcw_a, pcwc_a, bne_a, iord_a, mrd_a, mwr_a, m2r_a, irw_a, rdst_a, rw_a, asa_a, ill_a;
  logic [1:0]  asb_a, pcs_a;
  logic [2:0]  aop_a;
  logic [3:0]  st_a;
  logic [15:0] ret_a;

  // instance b
  logic        rst_b, mr_b;
  logic [5:0]  op_b;
  logic        pcw_b, pcwc_b, bne_b, iord_b, mrd_b, mwr_b, m2r_b, irw_b, rdst_b, rw_b, asa_b, ill_b;
  logic [1:0]  asb_b, pcs_b;
  logic [2:0]  aop_b;
  logic [3:0]  st_b;
  logic [3:0]  ret_b;

  multicycle_control_v2 #(.OPW(6), .ALUOP_W(3), .MEM_WAIT(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(rst_a), .opcode(op_a), .mem_ready(mr_a),
    .pc_write(pcw_a), .pc_write_cond(pcwc_a), .branch_ne(bne_a), .iord(iord_a),
    .mem_read(mrd_a), .mem_write(mwr_a), .mem_to_reg(m2r_a), .ir_write(irw_a),
    .reg_dst(rdst_a), .reg_write(rw_a), .alu_src_a(asa_a), .alu_src_b(asb_a),
    .pc_source(pcs_a), .alu_op(aop_a), .illegal_op(ill_a), .state_o(st_a), .retired(ret_a)
  );

  multicycle_control_v2 #(.OPW(6), .ALUOP_W(3), .MEM_WAIT(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(rst_b), .opcode(op_b), .mem_ready(mr_b),
    .pc_write(pcw_b), .pc_write_cond(pcwc_b), .branch_ne(bne_b), .iord(iord_b),
    .mem_read(mrd_b), .mem_write(mwr_b), .mem_to_reg(m2r_b), .ir_write(irw_b),
    .reg_dst(rdst_b), .reg_write(rw_b), .alu_src_a(asa_b), .alu_src_b(asb_b),
    .pc_source(pcs_b), .alu_op(aop_b), .illegal_op(ill_b), .state_o(st_b), .retired(ret_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_a = 1'b0; mr_a = 1'b0; op_a = 6'b000000;
    rst_b = 1'b0; mr_b = 1'b0; op_b = 6'b100011;
    step();
    step();

    // ---------------- instance b: MEM_WAIT=0, CNT_W=4 ----------------
    chk("b_rst_state", st_b, 0);
    chk("b_rst_retired", ret_b, 0);
    chk("b_rst_irw", irw_b, 1);
    chk("b_rst_pcw", pcw_b, 1);
    chk("b_rst_mwr", mwr_b, 0);
    chk("b_rst_rw", rw_b, 0);
    rst_b = 1'b1;
    step();
    chk("b_lw_c2_state", st_b, 1);
    chk("b_lw_c2_asb", asb_b, 3);
    step();
    chk("b_lw_c3_state", st_b, 2);
    chk("b_lw_c3_asa", asa_b, 1);
    chk("b_lw_c3_asb", asb_b, 2);
    step();
    chk("b_lw_c4_state", st_b, 3);
    chk("b_lw_c4_iord", iord_b, 1);
    chk("b_lw_c4_mrd", mrd_b, 1);
    step();
    chk("b_lw_c5_state", st_b, 4);
    chk("b_lw_c5_rw", rw_b, 1);
    chk("b_lw_c5_m2r", m2r_b, 1);
    chk("b_lw_c5_retired", ret_b, 0);
    step();
    chk("b_lw_end_state", st_b, 0);
    chk("b_lw_end_retired", ret_b, 1);
    repeat (14) repeat (5) step();
    chk("b_wrap_pre_state", st_b, 0);
    chk("b_wrap_pre_retired", ret_b, 15);
    repeat (5) step();
    chk("b_wrap_retired", ret_b, 0);
    op_b = 6'b000010;
    step();
    chk("b_j_decode", st_b, 1);
    step();
    chk("b_j_state", st_b, 11);
    chk("b_j_pcw", pcw_b, 1);
    chk("b_j_pcs", pcs_b, 2);
    step();
    chk("b_j_end_state", st_b, 0);
    chk("b_j_retired", ret_b, 1);

    // ---------------- instance a: MEM_WAIT=1, CNT_W=16 ----------------
    chk("a_rst_state", st_a, 0);
    chk("a_rst_retired", ret_a, 0);
    chk("a_rst_mrd", mrd_a, 1);
    chk("a_rst_asb", asb_a, 1);
    chk("a_rst_irw", irw_a, 0);
    chk("a_rst_pcw", pcw_a, 0);
    chk("a_rst_rw", rw_a, 0);
    chk("a_rst_mwr", mwr_a, 0);
    rst_a = 1'b1;
    op_a = 6'b101011;
    step();
    chk("a_fstall1_state", st_a, 0);
    chk("a_fstall1_irw", irw_a, 0);
    chk("a_fstall1_pcw", pcw_a, 0);
    step();
    chk("a_fstall2_state", st_a, 0);
    chk("a_fstall2_irw", irw_a, 0);
    mr_a = 1'b1;
    #1;
    chk("a_fready_irw", irw_a, 1);
    chk("a_fready_pcw", pcw_a, 1);
    step();
    chk("a_sw_decode", st_a, 1);
    mr_a = 1'b0;
    step();
    chk("a_sw_memadr", st_a, 2);
    step();
    chk("a_sw_w1_state", st_a, 5);
    chk("a_sw_w1_mwr", mwr_a, 1);
    chk("a_sw_w1_iord", iord_a, 1);
    step();
    chk("a_sw_w2_state", st_a, 5);
    chk("a_sw_w2_mwr", mwr_a, 1);
    step();
    chk("a_sw_w3_mwr", mwr_a, 1);
    chk("a_sw_w3_iord", iord_a, 1);
    step();
    mr_a = 1'b1;
    #1;
    chk("a_sw_w4_state", st_a, 5);
    chk("a_sw_w4_mwr", mwr_a, 1);
    chk("a_sw_w4_iord", iord_a, 1);
    step();
    chk("a_sw_end_state", st_a, 0);
    chk("a_sw_retired", ret_a, 1);

    op_a = 6'b000101;
    step();
    step();
    chk("a_bne_state", st_a, 12);
    chk("a_bne_pcwc", pcwc_a, 1);
    chk("a_bne_bne", bne_a, 1);
    chk("a_bne_aop", aop_a, 1);
    chk("a_bne_pcs", pcs_a, 1);
    chk("a_bne_pcw", pcw_a, 0);
    step();
    chk("a_bne_retired", ret_a, 2);

    op_a = 6'b001101;
    step();
    step();
    chk("a_ori_state", st_a, 9);
    op_a = 6'b001100;
    #1;
    chk("a_ori_aop", aop_a, 4);
    chk("a_ori_asb", asb_a, 2);
    step();
    chk("a_ori_iwb_state", st_a, 10);
    chk("a_ori_iwb_rw", rw_a, 1);
    chk("a_ori_iwb_rdst", rdst_a, 0);
    step();
    chk("a_ori_retired", ret_a, 3);

    op_a = 6'b111111;
    step();
    step();
    chk("a_ill_state", st_a, 13);
    chk("a_ill_pulse", ill_a, 1);
    chk("a_ill_rw", rw_a, 0);
    chk("a_ill_mwr", mwr_a, 0);
    chk("a_ill_pcw", pcw_a, 0);
    step();
    chk("a_ill_end_state", st_a, 0);
    chk("a_ill_end_pulse", ill_a, 0);
    chk("a_ill_retired", ret_a, 3);

    op_a = 6'b100011;
    step();
    step();
    step();
    chk("a_lw_memrd", st_a, 3);
    mr_a = 1'b0;
    rst_a = 1'b0;
    step();
    chk("a_midrst_state", st_a, 0);
    chk("a_midrst_retired", ret_a, 0);

    rst_a = 1'b1;
    mr_a = 1'b1;
    op_a = 6'b000000;
    step();
    step();
    chk("a_r_exec_state", st_a, 6);
    chk("a_r_exec_aop", aop_a, 2);
    chk("a_r_exec_asa", asa_a, 1);
    step();
    chk("a_r_rwb_rw", rw_a, 1);
    chk("a_r_rwb_rdst", rdst_a, 1);
    step();
    chk("a_r_retired", ret_a, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
